button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, SHALL set the consecutive stable cycles required to accept a level change; legal range >= 2.
REQ-002 Parameter LONG_PRESS_CYCLES, default 25000000, SHALL set the cycles a debounced press must persist before o_long fires; it SHALL be greater than DEBOUNCE_CYCLES.
REQ-003 CLK  input  1  SHALL be the single system clock; all logic on posedge CLK.
REQ-004 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-005 i_BUT  input  1  SHALL be the raw asynchronous button pin: 1 = released, 0 = pressed.
REQ-006 o_BUT  output  1  SHALL be the debounced level, same polarity as i_BUT.
REQ-007 o_press  output  1  SHALL be a one-cycle pulse on an accepted 1->0 transition.
REQ-008 o_release  output  1  SHALL be a one-cycle pulse on an accepted 0->1 transition.
REQ-009 o_long  output  1  SHALL be a one-cycle long-press pulse; the port SHALL always exist.

Function
REQ-010 i_BUT SHALL pass through a 2-flop synchronizer; only the second flop output (s_BUT) SHALL feed logic.
REQ-011 FSM states SHALL be RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-012 RELEASED: s_BUT=0 -> PRESS_PEND with debounce counter cleared; otherwise stay.
REQ-013 PRESS_PEND: counter increments each cycle s_BUT=0; s_BUT=1 -> RELEASED, counter cleared, no pulse.
REQ-014 PRESS_PEND with counter = DEBOUNCE_CYCLES-1 and s_BUT=0 -> PRESSED; o_BUT<=0 and o_press<=1 on that same edge.
REQ-015 PRESSED/RELEASE_PEND SHALL mirror REQ-012..014 with polarity swapped, producing o_BUT<=1 and o_release<=1.
REQ-016 Latency: raw edge stable from cycle k SHALL update o_BUT and assert its pulse at edge k+1+DEBOUNCE_CYCLES (2 sync + DEBOUNCE_CYCLES-1 counting), exactly.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change and no pulse.
REQ-018 o_press, o_release, o_long SHALL each be high for exactly one cycle per event and never simultaneously.
REQ-019 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES); it SHALL never wrap.
REQ-020 o_BUT SHALL be registered and glitch-free.

Reset
REQ-021 RST=1 SHALL force: sync flops 1, state RELEASED, all counters 0, o_BUT=1, o_press=o_release=o_long=0, on the next edge.
REQ-022 Reset asserted mid-debounce or mid-long-press SHALL abort it with no pulse emitted.
REQ-023 Button held low across reset release SHALL yield o_press exactly at REQ-016 latency after RST deasserts.

Configuration
REQ-024 Macro BUTTON_LONG_PRESS_EN defined: a long counter SHALL count cycles in PRESSED (cleared on entry) and pulse o_long once when it reaches LONG_PRESS_CYCLES-1, then saturate; leaving PRESSED clears it; RELEASE_PEND bounces back to PRESSED SHALL NOT clear it.
REQ-025 Macro undefined: long counter SHALL not be synthesized; o_long SHALL be constant 0.

Structure
REQ-026 Shared package button_pkg SHALL hold the FSM state typedef and default DEBOUNCE_CYCLES/LONG_PRESS_CYCLES constants.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff (CLK, RST, d, q; reset value parameter, here 1).
REQ-028 Output is drop-in for the downstream LED-toggle stage: its falling-edge detect on o_BUT SHALL coincide with o_press.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=12)
REQ-029 Clean press: i_BUT 1->0 at cycle 10, held -> o_BUT=0 and o_press=1 at cycle 15 only.
REQ-030 Bounce: i_BUT low cycles 10-12, high 13, low from 14 -> no pulse before cycle 19; o_press at 19.
REQ-031 Release: after REQ-029, i_BUT 0->1 at cycle 40 -> o_release=1 and o_BUT=1 at cycle 45.
REQ-032 Long press (macro on): press from cycle 10 -> o_press at 15, o_long at 27 once; macro off -> o_long 0 throughout.
REQ-033 Reset mid-debounce: press at 10, RST=1 cycle 12 only -> no pulse until cycle 18 (o_press), outputs at reset values cycle 13.
REQ-034 Short glitch: i_BUT low cycles 10-12 only -> o_BUT stays 1, no pulses for 50 cycles.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES   = 250000;
    localparam int DEF_LONG_PRESS_CYCLES = 25000000;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic r_meta;

    // Metastability filter: d -> r_meta -> q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_meta <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounced button with press/release pulses; optional long-press pulse when
// BUTTON_LONG_PRESS_EN is defined (otherwise o_long is tied low).
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_BUT,
    output logic o_BUT,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic            w_s_but;
    btn_state_t      r_state;
    logic [DB_W-1:0] r_db_cnt;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (i_BUT),
        .q   (w_s_but)
    );

    // Debounce FSM; the sample that leaves a stable state is already the first
    // stable sample, so the pending count starts at 1 and never exceeds DB_LAST.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= RELEASED;
            r_db_cnt  <= '0;
            o_BUT     <= 1'b1;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (!w_s_but) begin
                        r_state  <= PRESS_PEND;
                        r_db_cnt <= DB_ONE;
                    end else begin
                        r_db_cnt <= '0;
                    end
                end
                PRESS_PEND: begin
                    if (w_s_but) begin
                        r_state  <= RELEASED;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state  <= PRESSED;
                        r_db_cnt <= '0;
                        o_BUT    <= 1'b0;
                        o_press  <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                PRESSED: begin
                    if (w_s_but) begin
                        r_state  <= RELEASE_PEND;
                        r_db_cnt <= DB_ONE;
                    end else begin
                        r_db_cnt <= '0;
                    end
                end
                RELEASE_PEND: begin
                    if (!w_s_but) begin
                        r_state  <= PRESSED;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state   <= RELEASED;
                        r_db_cnt  <= '0;
                        o_BUT     <= 1'b1;
                        o_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                default: begin
                    r_state  <= RELEASED;
                    r_db_cnt <= '0;
                    o_BUT    <= 1'b1;
                end
            endcase
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_PRESS_CYCLES);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

    logic [LONG_W-1:0] r_long_cnt;

    // Long-press timer: held through release bounces, parked at LONG_SAT after firing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_long_cnt <= '0;
            o_long     <= 1'b0;
        end else begin
            o_long <= 1'b0;
            case (r_state)
                PRESSED: begin
                    if (r_long_cnt == LONG_LAST) begin
                        o_long     <= 1'b1;
                        r_long_cnt <= LONG_SAT;
                    end else if (r_long_cnt != LONG_SAT) begin
                        r_long_cnt <= r_long_cnt + LONG_ONE;
                    end else begin
                        r_long_cnt <= LONG_SAT;
                    end
                end
                RELEASE_PEND: r_long_cnt <= r_long_cnt;
                default:      r_long_cnt <= '0;
            endcase
        end
    end
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Table-driven bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=12.
module tb_button_conditioner;

    localparam int DB   = 4;
    localparam int LP   = 12;
    localparam int NCYC = 60;
    localparam int NVEC = 7;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic i_BUT = 1'b1;
    logic o_BUT, o_press, o_release, o_long;

    int n_checks = 0;
    int n_errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .i_BUT     (i_BUT),
        .o_BUT     (o_BUT),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    always #5 CLK = ~CLK;

    // Low windows [lo_s, lo_e] on i_BUT (-1 = unused), extra reset cycle,
    // and expected event cycles (-1 = event must never occur).
    typedef struct {
        int lo1_s, lo1_e, lo2_s, lo2_e;
        int rst_c;
        int press_c, release_c, long_c;
    } vec_t;

    vec_t       tbl [NVEC];
    logic [3:0] exp_q [$];

    function automatic logic in_win(input int c, input int s, input int e);
        return (s >= 0) && (c >= s) && (c <= e);
    endfunction

    function automatic logic [3:0] expect_at(input vec_t v, input int c);
        logic e_but, e_press, e_rel, e_long;
        e_but   = !((v.press_c >= 0) && (c >= v.press_c) &&
                    ((v.release_c < 0) || (c < v.release_c)));
        e_press = (c == v.press_c);
        e_rel   = (c == v.release_c);
`ifdef BUTTON_LONG_PRESS_EN
        e_long  = (c == v.long_c);
`else
        e_long  = 1'b0;
`endif
        return {e_but, e_press, e_rel, e_long};
    endfunction

    initial begin
        // clean press
        tbl[0] = '{10, 999, -1, -1, -1, 15, -1, 27};
        // bounce during press debounce
        tbl[1] = '{10, 12, 14, 999, -1, 19, -1, 31};
        // press then release at 40
        tbl[2] = '{10, 39, -1, -1, -1, 15, 45, 27};
        // reset mid-debounce at cycle 12
        tbl[3] = '{10, 999, -1, -1, 12, 18, -1, 30};
        // short glitch
        tbl[4] = '{10, 12, -1, -1, -1, -1, -1, -1};
        // one-cycle release bounce must not restart the long timer
        tbl[5] = '{10, 20, 22, 999, -1, 15, -1, 28};
        // held low across reset release
        tbl[6] = '{0, 999, -1, -1, -1, 8, -1, 20};

        for (int v = 0; v < NVEC; v++) begin
            for (int c = 0; c < NCYC; c++) begin
                logic [3:0] exp_v;
                logic [3:0] act_v;
                @(negedge CLK);
                RST   = (c <= 2) || (c == tbl[v].rst_c);
                i_BUT = !(in_win(c, tbl[v].lo1_s, tbl[v].lo1_e) ||
                          in_win(c, tbl[v].lo2_s, tbl[v].lo2_e));
                exp_q.push_back(expect_at(tbl[v], c));
                @(posedge CLK);
                #1;
                act_v = {o_BUT, o_press, o_release, o_long};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_empty scn%0d cyc%0d got %b expected an entry", v, c, act_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act_v !== exp_v) begin
                        n_errors++;
                        $display("FAIL scn%0d cyc%0d {BUT,press,rel,long} got %b expected %b",
                                 v, c, act_v, exp_v);
                    end
                end
            end
        end

        // Hand-written sequence: reset forced from the pressed state gives reset values next edge.
        @(negedge CLK);
        RST   = 1'b0;
        i_BUT = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        n_checks++;
        if (o_BUT !== 1'b0) begin
            n_errors++;
            $display("FAIL pressed_before_reset o_BUT got %b expected 0", o_BUT);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++;
        if ({o_BUT, o_press, o_release, o_long} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_from_pressed got %b expected 1000",
                     {o_BUT, o_press, o_release, o_long});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
